// File: rtl/mem_pkg.sv
// Shared definitions for the cache-side memory protocol and the arbiter FSM.
package mem_pkg;

  localparam logic [1:0] MEM_NONE    = 2'd0;
  localparam logic [1:0] MEM_READ    = 2'd1;
  localparam logic [1:0] MEM_WRITE   = 2'd2;
  localparam logic [1:0] MEM_ILLEGAL = 2'd3;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } arb_state_e;

  // Request layout for the default 32/32 configuration; the arbiter builds the
  // same layout from its own parameters.
  typedef struct packed {
    logic [1:0]              flag;
    logic [MEM_ADDR_W-1:0]   addr;
    logic [MEM_DATA_W-1:0]   data;
    logic [MEM_DATA_W/8-1:0] mask;
  } mem_req_t;

  function automatic logic is_request(input logic [1:0] flag);
    return (flag == MEM_READ) || (flag == MEM_WRITE);
  endfunction

endpackage

// File: rtl/req_slot.sv
// One-entry request buffer: captures a request when empty and unblocked,
// flags an overflow when a request arrives that cannot be held.
module req_slot
  import mem_pkg::*;
#(
  parameter type req_t = mem_req_t
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic block_i,
  input  logic clear_i,
  input  req_t req_i,
  output logic valid_o,
  output req_t req_o,
  output logic err_o
);

  logic valid_q;
  req_t req_q;
  logic accept;

  assign accept  = load_i && !valid_q && !block_i;
  assign err_o   = load_i && (valid_q || block_i);
  assign valid_o = valid_q;
  assign req_o   = req_q;

  // clear_i only fires on a valid slot and accept needs an empty one, so
  // the two never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      req_q   <= req_i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one downstream memory port between the I-cache (port 0) and the
// D-cache (port 1); D-cache writes also flush the matching I-cache line.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              p0_rw_flag_i,
  input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
  input  logic [DATA_WIDTH-1:0]   p0_w_data_i,
  input  logic [DATA_WIDTH/8-1:0] p0_w_mask_i,
  output logic [DATA_WIDTH-1:0]   p0_r_data_o,
  output logic                    p0_busy_o,
  output logic                    p0_done_o,
  input  logic [1:0]              p1_rw_flag_i,
  input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
  input  logic [DATA_WIDTH-1:0]   p1_w_data_i,
  input  logic [DATA_WIDTH/8-1:0] p1_w_mask_i,
  output logic [DATA_WIDTH-1:0]   p1_r_data_o,
  output logic                    p1_busy_o,
  output logic                    p1_done_o,
  output logic [1:0]              mem_rw_flag_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_w_data_o,
  output logic [DATA_WIDTH/8-1:0] mem_w_mask_o,
  input  logic [DATA_WIDTH-1:0]   mem_r_data_i,
  input  logic                    mem_busy,
  input  logic                    mem_done,
  output logic                    icache_flush_flag_o,
  output logic [ADDR_WIDTH-1:0]   icache_flush_addr_o,
  output logic                    err_o
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  typedef struct packed {
    logic [1:0]            flag;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [MASK_WIDTH-1:0] mask;
  } req_t;

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic       err_q, err_d;

  logic [1:0] flag_in [2];
  req_t       req_in  [2];
  req_t       req_out [2];
  logic [1:0] load, block, clear, valid, ovf, done;
  logic       sel;
  req_t       issue;

  assign flag_in[0] = p0_rw_flag_i;
  assign flag_in[1] = p1_rw_flag_i;
  assign req_in[0]  = '{p0_rw_flag_i, p0_addr_i, p0_w_data_i, p0_w_mask_i};
  assign req_in[1]  = '{p1_rw_flag_i, p1_addr_i, p1_w_data_i, p1_w_mask_i};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      assign load[gi] = is_request(flag_in[gi]);
      // The owner may queue its next request in the cycle its done arrives.
      assign block[gi] = (state_q == ST_WAIT) && (owner_q == 1'(gi)) && !mem_done;

      req_slot #(.req_t(req_t)) u_slot (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load[gi]),
        .block_i (block[gi]),
        .clear_i (clear[gi]),
        .req_i   (req_in[gi]),
        .valid_o (valid[gi]),
        .req_o   (req_out[gi]),
        .err_o   (ovf[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    clear   = 2'b00;
    done    = 2'b00;
    sel     = 1'b0;
    issue   = '0;
    err_d   = err_q | (|ovf) | (p0_rw_flag_i == MEM_ILLEGAL)
                             | (p1_rw_flag_i == MEM_ILLEGAL);
    case (state_q)
      ST_IDLE: begin
        if ((|valid) && !mem_busy) begin
          if (&valid) sel = (FIXED_PRIO != 0) ? 1'b1 : ~last_q;
          else        sel = valid[1];
          issue      = req_out[sel];
          clear[sel] = 1'b1;
          owner_d    = sel;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_done) begin
          done[owner_q] = 1'b1;
          last_d        = owner_q;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_rw_flag_o = issue.flag;
  assign mem_addr_o    = issue.addr;
  assign mem_w_data_o  = issue.data;
  assign mem_w_mask_o  = issue.mask;

  assign icache_flush_flag_o = sel && (issue.flag == MEM_WRITE);
  assign icache_flush_addr_o = icache_flush_flag_o ? issue.addr : '0;

  assign p0_done_o   = done[0];
  assign p1_done_o   = done[1];
  assign p0_r_data_o = done[0] ? mem_r_data_i : '0;
  assign p1_r_data_o = done[1] ? mem_r_data_i : '0;
  assign p0_busy_o   = valid[0] || ((state_q == ST_WAIT) && !owner_q);
  assign p1_busy_o   = valid[1] || ((state_q == ST_WAIT) && owner_q);
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance (u_rr) and a
// fixed-priority instance (u_fp) sharing payload inputs but not flags.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  p0_flag, p1_flag, b_p0_flag, b_p1_flag;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata, mem_rdata;
  logic [3:0]  p0_wmask, p1_wmask;
  logic        mem_busy, mem_done, b_mem_done;

  logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, fl_addr;
  logic        p0_busy, p1_busy, p0_done, p1_done, fl_flag, err;
  logic [1:0]  mem_flag;
  logic [3:0]  mem_wmask;

  logic [31:0] b_p0_rdata, b_p1_rdata, b_mem_addr, b_mem_wdata, b_fl_addr;
  logic        b_p0_busy, b_p1_busy, b_p0_done, b_p1_done, b_fl_flag, b_err;
  logic [1:0]  b_mem_flag;
  logic [3:0]  b_mem_wmask;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst),
    .p0_rw_flag_i(p0_flag), .p0_addr_i(p0_addr), .p0_w_data_i(p0_wdata), .p0_w_mask_i(p0_wmask),
    .p0_r_data_o(p0_rdata), .p0_busy_o(p0_busy), .p0_done_o(p0_done),
    .p1_rw_flag_i(p1_flag), .p1_addr_i(p1_addr), .p1_w_data_i(p1_wdata), .p1_w_mask_i(p1_wmask),
    .p1_r_data_o(p1_rdata), .p1_busy_o(p1_busy), .p1_done_o(p1_done),
    .mem_rw_flag_o(mem_flag), .mem_addr_o(mem_addr), .mem_w_data_o(mem_wdata), .mem_w_mask_o(mem_wmask),
    .mem_r_data_i(mem_rdata), .mem_busy(mem_busy), .mem_done(mem_done),
    .icache_flush_flag_o(fl_flag), .icache_flush_addr_o(fl_addr), .err_o(err)
  );

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst),
    .p0_rw_flag_i(b_p0_flag), .p0_addr_i(p0_addr), .p0_w_data_i(p0_wdata), .p0_w_mask_i(p0_wmask),
    .p0_r_data_o(b_p0_rdata), .p0_busy_o(b_p0_busy), .p0_done_o(b_p0_done),
    .p1_rw_flag_i(b_p1_flag), .p1_addr_i(p1_addr), .p1_w_data_i(p1_wdata), .p1_w_mask_i(p1_wmask),
    .p1_r_data_o(b_p1_rdata), .p1_busy_o(b_p1_busy), .p1_done_o(b_p1_done),
    .mem_rw_flag_o(b_mem_flag), .mem_addr_o(b_mem_addr), .mem_w_data_o(b_mem_wdata), .mem_w_mask_o(b_mem_wmask),
    .mem_r_data_i(mem_rdata), .mem_busy(mem_busy), .mem_done(b_mem_done),
    .icache_flush_flag_o(b_fl_flag), .icache_flush_addr_o(b_fl_addr), .err_o(b_err)
  );

  task automatic clear_inputs();
    p0_flag = 2'd0; p1_flag = 2'd0; b_p0_flag = 2'd0; b_p1_flag = 2'd0;
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
    p0_wmask = '0; p1_wmask = '0; mem_rdata = '0;
    mem_busy = 1'b0; mem_done = 1'b0; b_mem_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({mem_flag, mem_addr, mem_wdata, mem_wmask, fl_flag, fl_addr, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: mem_flag=%0d addr=%h fl=%b err=%b, required all 0",
               mem_flag, mem_addr, fl_flag, err);
    end
    checks++;
    if ({p0_busy, p1_busy, p0_done, p1_done, p0_rdata, p1_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_ports: busy=%b%b done=%b%b, required 0", p0_busy, p1_busy, p0_done, p1_done);
    end
    $display("test_reset: outputs checked after reset");
  endtask

  task automatic test_single_read();
    do_reset();
    @(negedge clk); p0_flag = 2'd1; p0_addr = 32'h100;
    @(negedge clk); p0_flag = 2'd0; #1;
    checks++;
    if (mem_flag !== 2'd1 || mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL single_issue: flag=%0d addr=%h, required 1/00000100", mem_flag, mem_addr);
    end
    checks++;
    if (p0_busy !== 1'b1) begin
      errors++; $display("FAIL single_busy: p0_busy=%b, required 1", p0_busy);
    end
    @(negedge clk); #1;
    checks++;
    if (mem_flag !== 2'd0) begin
      errors++; $display("FAIL single_pulse: mem_flag=%0d in WAIT, required 0", mem_flag);
    end
    @(negedge clk);
    @(negedge clk); mem_done = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
    checks++;
    if (p0_done !== 1'b1 || p0_rdata !== 32'hDEADBEEF || p1_done !== 1'b0) begin
      errors++;
      $display("FAIL single_done: p0_done=%b data=%h p1_done=%b, required 1/deadbeef/0",
               p0_done, p0_rdata, p1_done);
    end
    @(negedge clk); mem_done = 1'b0; #1;
    checks++;
    if (p0_busy !== 1'b0 || p0_done !== 1'b0 || p0_rdata !== 32'h0) begin
      errors++;
      $display("FAIL single_after: busy=%b done=%b data=%h, required 0/0/0", p0_busy, p0_done, p0_rdata);
    end
    $display("test_single_read: p0 read 0x100 -> 0xdeadbeef");
  endtask

  task automatic test_two_ports();
    do_reset();
    @(negedge clk);
    p0_flag = 2'd1; p0_addr = 32'h10;
    p1_flag = 2'd2; p1_addr = 32'h20; p1_wdata = 32'h12345678; p1_wmask = 4'hF;
    @(negedge clk); p0_flag = 2'd0; p1_flag = 2'd0; #1;
    checks++;
    if (mem_flag !== 2'd1 || mem_addr !== 32'h10 || fl_flag !== 1'b0) begin
      errors++;
      $display("FAIL two_first: flag=%0d addr=%h flush=%b, required 1/00000010/0", mem_flag, mem_addr, fl_flag);
    end
    @(negedge clk); mem_done = 1'b1; mem_rdata = 32'hA5A5A5A5; #1;
    checks++;
    if (p0_done !== 1'b1 || p1_done !== 1'b0 || mem_flag !== 2'd0) begin
      errors++;
      $display("FAIL two_p0_done: p0_done=%b p1_done=%b mem_flag=%0d, required 1/0/0", p0_done, p1_done, mem_flag);
    end
    @(negedge clk); mem_done = 1'b0; #1;
    checks++;
    if (mem_flag !== 2'd2 || mem_addr !== 32'h20 || mem_wdata !== 32'h12345678 || mem_wmask !== 4'hF) begin
      errors++;
      $display("FAIL two_second: flag=%0d addr=%h data=%h mask=%h, required 2/00000020/12345678/f",
               mem_flag, mem_addr, mem_wdata, mem_wmask);
    end
    checks++;
    if (fl_flag !== 1'b1 || fl_addr !== 32'h20) begin
      errors++; $display("FAIL two_flush: flush=%b addr=%h, required 1/00000020", fl_flag, fl_addr);
    end
    @(negedge clk); mem_done = 1'b1; mem_rdata = 32'h0; #1;
    checks++;
    if (fl_flag !== 1'b0 || fl_addr !== 32'h0 || p1_done !== 1'b1 || p0_done !== 1'b0) begin
      errors++;
      $display("FAIL two_p1_done: flush=%b p1_done=%b p0_done=%b, required 0/1/0", fl_flag, p1_done, p0_done);
    end
    @(negedge clk); mem_done = 1'b0;
    $display("test_two_ports: p0 read then p1 write with flush");
  endtask

  task automatic test_round_robin();
    logic exp_port;
    do_reset();
    p0_addr = 32'h40; p1_addr = 32'h44;
    @(negedge clk); p0_flag = 2'd1; p1_flag = 2'd1;
    for (int i = 0; i < 4; i++) begin
      exp_port = i[0];
      @(negedge clk); p0_flag = 2'd0; p1_flag = 2'd0; mem_done = 1'b0; #1;
      checks++;
      if (mem_flag !== 2'd1 || mem_addr !== (exp_port ? 32'h44 : 32'h40)) begin
        errors++;
        $display("FAIL rr_grant%0d: flag=%0d addr=%h, required port %0d", i, mem_flag, mem_addr, exp_port);
      end
      @(negedge clk); mem_done = 1'b1; mem_rdata = 32'h1000 + i;
      if (exp_port) p1_flag = 2'd1; else p0_flag = 2'd1;
      #1;
      checks++;
      if (p0_done !== !exp_port || p1_done !== exp_port) begin
        errors++;
        $display("FAIL rr_done%0d: p0_done=%b p1_done=%b, required port %0d", i, p0_done, p1_done, exp_port);
      end
      $display("rr transaction %0d: port %0d served", i, exp_port);
    end
    @(negedge clk); p0_flag = 2'd0; p1_flag = 2'd0; mem_done = 1'b0; #1;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL rr_no_err: err=%b after done-cycle requests, required 0", err);
    end
  endtask

  task automatic test_fixed_prio();
    do_reset();
    p0_addr = 32'h40; p1_addr = 32'h44;
    @(negedge clk); b_p0_flag = 2'd1; b_p1_flag = 2'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); b_p0_flag = 2'd0; b_p1_flag = 2'd0; b_mem_done = 1'b0; #1;
      checks++;
      if (b_mem_flag !== 2'd1 || b_mem_addr !== 32'h44) begin
        errors++;
        $display("FAIL fp_grant%0d: flag=%0d addr=%h, required 1/00000044", i, b_mem_flag, b_mem_addr);
      end
      @(negedge clk); b_mem_done = 1'b1; b_p1_flag = 2'd1; #1;
      checks++;
      if (b_p1_done !== 1'b1 || b_p0_done !== 1'b0) begin
        errors++;
        $display("FAIL fp_done%0d: p1_done=%b p0_done=%b, required 1/0", i, b_p1_done, b_p0_done);
      end
      $display("fp transaction %0d: port 1 served", i);
    end
    @(negedge clk); b_p0_flag = 2'd0; b_p1_flag = 2'd0; b_mem_done = 1'b0; #1;
    checks++;
    if (b_p0_busy !== 1'b1) begin
      errors++; $display("FAIL fp_p0_pending: p0_busy=%b, required 1", b_p0_busy);
    end
  endtask

  task automatic test_overflow_err();
    do_reset();
    @(negedge clk); p1_flag = 2'd1; p1_addr = 32'h80;
    @(negedge clk); p1_flag = 2'd0;
    @(negedge clk); p1_flag = 2'd1; p1_addr = 32'h84;
    @(negedge clk); p1_flag = 2'd0; #1;
    checks++;
    if (err !== 1'b1 || p1_busy !== 1'b1) begin
      errors++; $display("FAIL ovf_err: err=%b busy=%b, required 1/1", err, p1_busy);
    end
    @(negedge clk); mem_done = 1'b1; mem_rdata = 32'hCAFEF00D; #1;
    checks++;
    if (p1_done !== 1'b1 || p1_rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL ovf_done: done=%b data=%h, required 1/cafef00d", p1_done, p1_rdata);
    end
    @(negedge clk); mem_done = 1'b0; #1;
    checks++;
    if (mem_flag !== 2'd0 || err !== 1'b1 || p1_busy !== 1'b0) begin
      errors++;
      $display("FAIL ovf_dropped: mem_flag=%0d err=%b busy=%b, required 0/1/0", mem_flag, err, p1_busy);
    end
    $display("test_overflow_err: second p1 request dropped");
  endtask

  task automatic test_illegal_flag();
    do_reset();
    @(negedge clk); p0_flag = 2'd3; p0_addr = 32'h90;
    @(negedge clk); p0_flag = 2'd0; #1;
    checks++;
    if (err !== 1'b1 || mem_flag !== 2'd0 || p0_busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_flag: err=%b mem_flag=%0d busy=%b, required 1/0/0", err, mem_flag, p0_busy);
    end
    $display("test_illegal_flag: flag 3 rejected");
  endtask

  task automatic test_mem_busy();
    do_reset();
    mem_busy = 1'b1;
    @(negedge clk); p0_flag = 2'd1; p0_addr = 32'h200;
    @(negedge clk); p0_flag = 2'd0; #1;
    checks++;
    if (mem_flag !== 2'd0 || p0_busy !== 1'b1) begin
      errors++; $display("FAIL busy_hold1: mem_flag=%0d busy=%b, required 0/1", mem_flag, p0_busy);
    end
    @(negedge clk); #1;
    checks++;
    if (mem_flag !== 2'd0) begin
      errors++; $display("FAIL busy_hold2: mem_flag=%0d, required 0", mem_flag);
    end
    @(negedge clk); mem_busy = 1'b0; #1;
    checks++;
    if (mem_flag !== 2'd1 || mem_addr !== 32'h200) begin
      errors++; $display("FAIL busy_release: flag=%0d addr=%h, required 1/00000200", mem_flag, mem_addr);
    end
    @(negedge clk); mem_done = 1'b1;
    @(negedge clk); mem_done = 1'b0;
    $display("test_mem_busy: issue deferred until mem_busy low");
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk); p0_flag = 2'd1; p0_addr = 32'h300;
    @(negedge clk); p0_flag = 2'd0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    @(negedge clk); mem_done = 1'b1; mem_rdata = 32'h77777777; #1;
    checks++;
    if (p0_done !== 1'b0 || p1_done !== 1'b0 || p0_rdata !== 32'h0 || mem_flag !== 2'd0 || p0_busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_stale: p0_done=%b p1_done=%b data=%h mem_flag=%0d busy=%b, required all 0",
               p0_done, p1_done, p0_rdata, mem_flag, p0_busy);
    end
    @(negedge clk); mem_done = 1'b0; p0_flag = 2'd1; p0_addr = 32'h304;
    @(negedge clk); p0_flag = 2'd0; #1;
    checks++;
    if (mem_flag !== 2'd1 || mem_addr !== 32'h304) begin
      errors++; $display("FAIL midrst_fresh: flag=%0d addr=%h, required 1/00000304", mem_flag, mem_addr);
    end
    @(negedge clk); mem_done = 1'b1; mem_rdata = 32'h0BADF00D; #1;
    checks++;
    if (p0_done !== 1'b1 || p0_rdata !== 32'h0BADF00D) begin
      errors++; $display("FAIL midrst_done: done=%b data=%h, required 1/0badf00d", p0_done, p0_rdata);
    end
    @(negedge clk); mem_done = 1'b0;
    $display("test_reset_mid: stale done ignored, fresh read served");
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_two_ports();
    test_round_robin();
    test_fixed_prio();
    test_overflow_err();
    test_illegal_flag();
    test_mem_busy();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
